fb_writer: RTL and testbench



---
 rtl/fb_pkg.sv | 37 +++
 rtl/fb_writer_if.sv | 27 ++
 rtl/fb_addr_gen.sv | 64 ++++++
 rtl/fb_writer.sv | 111 +++++++++++
 tb/tb_fb_writer.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared constants, types and address helpers for the double-buffered frame-buffer writer.
package fb_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned COLOR_W  = 3;
  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned COORD_W  = 10;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    DRAW       = 2'd0,
    FLUSH      = 2'd1,
    WAIT_VSYNC = 2'd2,
    START      = 2'd3
  } fb_state_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    color_t color;
  } pixel_t;

  function automatic logic in_screen(input coord_t x, input coord_t y);
    return (x < COORD_W'(SCREEN_W)) && (y < COORD_W'(SCREEN_H));
  endfunction

  // y*640 + x built from two shifts so no multiplier is inferred
  function automatic logic [ADDR_W-1:0] lin_addr(input coord_t x, input coord_t y);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    return (yw << 9) + (yw << 7) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/fb_writer_if.sv
// Pixel stream and memory write bus of the frame-buffer writer.
// The master modport is the writer's view: pixel sink and write-bus initiator.
interface fb_writer_if;
  import fb_pkg::*;

  logic              px_valid;
  coord_t            px_x;
  coord_t            px_y;
  color_t            px_color;
  logic              px_ready;

  logic              mem_wr_en;
  logic [ADDR_W:0]   mem_addr;
  color_t            mem_wr_data;
  logic              mem_wr_ready;

  modport master (
    input  px_valid, px_x, px_y, px_color, mem_wr_ready,
    output px_ready, mem_wr_en, mem_addr, mem_wr_data
  );

  modport slave (
    output px_valid, px_x, px_y, px_color, mem_wr_ready,
    input  px_ready, mem_wr_en, mem_addr, mem_wr_data
  );

endinterface

// File: rtl/fb_addr_gen.sv
// Two-stage pixel pipeline: S1 holds an in-range pixel plus its bank, S2 holds the
// linear address and colour that drive the memory write port.
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              s1_en,
  input  logic              s2_en,
  input  logic              load,
  input  pixel_t            pix,
  input  logic              bank,
  output logic              in_range,
  output logic              s1_valid,
  output logic              s2_valid,
  output logic [ADDR_W:0]   wr_addr,
  output color_t            wr_color
);

  logic            s1_valid_r;
  pixel_t          s1_pix_r;
  logic            s1_bank_r;
  logic            s2_valid_r;
  logic [ADDR_W:0] s2_addr_r;
  color_t          s2_color_r;

  assign in_range = in_screen(pix.x, pix.y);

  // S1: capture accepted in-range pixels; a bubble is loaded when nothing valid arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_pix_r   <= '0;
      s1_bank_r  <= 1'b0;
    end else if (s1_en) begin
      s1_valid_r <= load;
      if (load) begin
        s1_pix_r  <= pix;
        s1_bank_r <= bank;
      end
    end
  end

  // S2: address computation; contents are frozen while the memory stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_addr_r  <= '0;
      s2_color_r <= '0;
    end else if (s2_en) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_addr_r  <= {s1_bank_r, lin_addr(s1_pix_r.x, s1_pix_r.y)};
        s2_color_r <= s1_pix_r.color;
      end
    end
  end

  assign s1_valid = s1_valid_r;
  assign s2_valid = s2_valid_r;
  assign wr_addr  = s2_addr_r;
  assign wr_color = s2_color_r;

endmodule

// File: rtl/fb_writer.sv
// Frame-buffer writer: pixels from the line generator are written into the back bank;
// banks swap at vsync once the frame has been flushed, then the next frame is started.
module fb_writer
  import fb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fb_writer_if.master        bus,
  input  logic               raster_done,
  input  logic               vsync,
  output logic               frame_start,
  output logic               disp_sel,
  output logic [15:0]        drop_cnt
);

  fb_state_t       state_r;
  fb_state_t       nxt_s;
  logic            frame_start_r;
  logic            disp_sel_r;
  logic [15:0]     drop_cnt_r;

  logic            s1_valid_s;
  logic            s2_valid_s;
  logic            in_range_s;
  logic            s1_adv_s;
  logic            s2_adv_s;
  logic            px_ready_s;
  logic            accept_s;
  logic            load_s;
  logic            drop_s;
  pixel_t          pix_s;
  logic [ADDR_W:0] wr_addr_s;
  color_t          wr_color_s;

  assign pix_s = {bus.px_x, bus.px_y, bus.px_color};

  fb_addr_gen u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .s1_en    (s1_adv_s),
    .s2_en    (s2_adv_s),
    .load     (load_s),
    .pix      (pix_s),
    .bank     (~disp_sel_r),
    .in_range (in_range_s),
    .s1_valid (s1_valid_s),
    .s2_valid (s2_valid_s),
    .wr_addr  (wr_addr_s),
    .wr_color (wr_color_s)
  );

  // Flow control and next-state logic
  always_comb begin
    nxt_s      = state_r;
    s2_adv_s   = !s2_valid_s || bus.mem_wr_ready;
    s1_adv_s   = !s1_valid_s || s2_adv_s;
    px_ready_s = (state_r == DRAW) && s1_adv_s;
    accept_s   = bus.px_valid && px_ready_s;
    load_s     = accept_s && in_range_s;
    drop_s     = accept_s && !in_range_s;
    case (state_r)
      DRAW: begin
        if (raster_done) nxt_s = FLUSH;
        else             nxt_s = DRAW;
      end
      FLUSH: begin
        if (!s1_valid_s && !s2_valid_s) nxt_s = WAIT_VSYNC;
        else                            nxt_s = FLUSH;
      end
      WAIT_VSYNC: begin
        if (vsync) nxt_s = START;
        else       nxt_s = WAIT_VSYNC;
      end
      START:   nxt_s = DRAW;
      default: nxt_s = START;
    endcase
  end

  // State register, bank select and the registered frame-start pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= START;
      frame_start_r <= 1'b0;
      disp_sel_r    <= 1'b1;
    end else begin
      state_r       <= nxt_s;
      frame_start_r <= (state_r == START);
      if ((state_r == WAIT_VSYNC) && vsync) begin
        disp_sel_r <= ~disp_sel_r;
      end
    end
  end

  // Saturating count of accepted off-screen pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= 16'd0;
    end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'd1;
    end
  end

  assign bus.px_ready    = px_ready_s;
  assign bus.mem_wr_en   = s2_valid_s;
  assign bus.mem_addr    = wr_addr_s;
  assign bus.mem_wr_data = wr_color_s;
  assign frame_start     = frame_start_r;
  assign disp_sel        = disp_sel_r;
  assign drop_cnt        = drop_cnt_r;

endmodule

// File: tb/tb_fb_writer.sv
// Bench for fb_writer: vector table plus hand sequences, with a write scoreboard.
module tb_fb_writer;

  logic        clk;
  logic        rst;
  logic        raster_done;
  logic        vsync;
  logic        frame_start;
  logic        disp_sel;
  logic [15:0] drop_cnt;

  fb_writer_if bus ();

  fb_writer dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .raster_done (raster_done),
    .vsync       (vsync),
    .frame_start (frame_start),
    .disp_sel    (disp_sel),
    .drop_cnt    (drop_cnt)
  );

  typedef struct packed {
    logic [19:0] addr;
    logic [2:0]  data;
  } wr_t;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  c;
    logic        wr;
    logic [18:0] addr;
  } vec_t;

  wr_t   sb[$];
  vec_t  vecs[9];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    acc = 0;
  int    wr_cnt = 0;
  int    exp_drop = 0;
  logic  exp_bank = 1'b0;
  logic        stall_prev = 1'b0;
  logic [19:0] stall_addr = 20'd0;
  logic [2:0]  stall_data = 3'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard pop and stall-stability check on the memory write port
  always @(negedge clk) begin
    wr_t e;
    if (bus.mem_wr_en && bus.mem_wr_ready) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: write addr 0x%0h data %0d, expected no write",
                 bus.mem_addr, bus.mem_wr_data);
      end else begin
        e = sb.pop_front();
        check("sb_write", {9'd0, bus.mem_addr, bus.mem_wr_data}, {9'd0, e.addr, e.data});
      end
    end
    if (stall_prev && !rst)
      check("stall_hold", {8'd0, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data},
            {8'd0, 1'b1, stall_addr, stall_data});
    stall_prev = bus.mem_wr_en && !bus.mem_wr_ready && !rst;
    stall_addr = bus.mem_addr;
    stall_data = bus.mem_wr_data;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a pixel and hold it until handshaked; leaves px_valid high
  task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [2:0] c,
                      input logic wr, input logic [18:0] a, output int waited);
    wr_t e;
    bus.px_x = x;
    bus.px_y = y;
    bus.px_color = c;
    bus.px_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.px_ready) break;
      waited++;
      if (waited > 60) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: pixel (%0d,%0d) not accepted, px_ready 0 expected 1", x, y);
        bus.px_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    acc++;
    if (wr) begin
      e.addr = {exp_bank, a};
      e.data = c;
      sb.push_back(e);
    end else begin
      exp_drop++;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || bus.mem_wr_en) && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int w;
    int s0;
    int w0;
    rst = 1'b1;
    raster_done = 1'b0;
    vsync = 1'b0;
    bus.px_valid = 1'b0;
    bus.px_x = 10'd0;
    bus.px_y = 10'd0;
    bus.px_color = 3'd0;
    bus.mem_wr_ready = 1'b1;

    vecs[0] = '{x: 10'd0,    y: 10'd0,    c: 3'd1, wr: 1'b1, addr: 19'd0};
    vecs[1] = '{x: 10'd639,  y: 10'd479,  c: 3'd3, wr: 1'b1, addr: 19'd307199};
    vecs[2] = '{x: 10'd639,  y: 10'd0,    c: 3'd7, wr: 1'b1, addr: 19'd639};
    vecs[3] = '{x: 10'd0,    y: 10'd1,    c: 3'd2, wr: 1'b1, addr: 19'd640};
    vecs[4] = '{x: 10'd1023, y: 10'd1023, c: 3'd4, wr: 1'b0, addr: 19'd0};
    vecs[5] = '{x: 10'd320,  y: 10'd240,  c: 3'd6, wr: 1'b1, addr: 19'd153920};
    vecs[6] = '{x: 10'd640,  y: 10'd479,  c: 3'd5, wr: 1'b0, addr: 19'd0};
    vecs[7] = '{x: 10'd5,    y: 10'd2,    c: 3'd5, wr: 1'b1, addr: 19'd1285};
    vecs[8] = '{x: 10'd639,  y: 10'd480,  c: 3'd1, wr: 1'b0, addr: 19'd0};

    // Reset state and first frame_start pulse
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_frame_start", frame_start, 0);
    check("rst_disp_sel", disp_sel, 1);
    check("rst_mem_wr_en", bus.mem_wr_en, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_px_ready", bus.px_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1);
    @(negedge clk);
    check("fs_first", frame_start, 1);
    check("fs_disp_sel", disp_sel, 1);
    check("fs_mem_wr_en", bus.mem_wr_en, 0);
    @(negedge clk);
    check("fs_single", frame_start, 0);
    check("ready_after_start", bus.px_ready, 1);
    check("idle_mem_wr_en", bus.mem_wr_en, 0);
    cyc(1);

    // Single pixel latency and address
    send(10'd5, 10'd2, 3'b101, 1'b1, 19'd1285, w);
    bus.px_valid = 1'b0;
    @(negedge clk);
    check("lat_s1_only", bus.mem_wr_en, 0);
    @(negedge clk);
    check("lat_wr_en", bus.mem_wr_en, 1);
    check("lat_addr", bus.mem_addr, {1'b0, 19'd1285});
    check("lat_data", bus.mem_wr_data, 3'b101);
    @(negedge clk);
    check("lat_one_cycle", bus.mem_wr_en, 0);
    cyc(1);

    // Off-screen pixels are accepted and counted but never written
    w0 = wr_cnt;
    send(10'd640, 10'd0, 3'd1, 1'b0, 19'd0, w);
    check("oob_x_no_stall", w, 0);
    send(10'd0, 10'd480, 3'd2, 1'b0, 19'd0, w);
    check("oob_y_no_stall", w, 0);
    send(10'd3, 10'd3, 3'd5, 1'b1, 19'd1923, w);
    check("inb_no_stall", w, 0);
    bus.px_valid = 1'b0;
    drain();
    check("oob_drop_cnt", drop_cnt, 2);
    check("oob_one_write", wr_cnt - w0, 1);

    // Vector table, back to back
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].wr, vecs[i].addr, w);
    end
    bus.px_valid = 1'b0;
    drain();
    check("table_drop_cnt", drop_cnt, exp_drop);

    // Stream of 20 pixels with a 10-cycle memory stall
    bus.mem_wr_ready = 1'b0;
    s0 = acc;
    fork
      begin
        int ws;
        for (int i = 0; i < 20; i++) begin
          send(10'(100 + i), 10'(10 + i % 3), 3'(i % 8), 1'b1,
               19'((10 + i % 3) * 640 + 100 + i), ws);
        end
        bus.px_valid = 1'b0;
      end
      begin
        repeat (10) @(negedge clk);
        check("stall_px_ready", bus.px_ready, 0);
        check("stall_accept_le2", ((acc - s0) <= 2) ? 1 : 0, 1);
        @(posedge clk);
        #1 bus.mem_wr_ready = 1'b1;
      end
    join
    drain();
    check("stream_accepted", acc - s0, 20);

    // raster_done with writes in flight; vsync ignored during FLUSH
    bus.mem_wr_ready = 1'b0;
    send(10'd10, 10'd20, 3'd3, 1'b1, 19'd12810, w);
    raster_done = 1'b1;
    send(10'd11, 10'd20, 3'd4, 1'b1, 19'd12811, w);
    check("rd_same_cycle_accept", w, 0);
    raster_done = 1'b0;
    bus.px_valid = 1'b0;
    @(negedge clk);
    check("flush_px_ready", bus.px_ready, 0);
    @(posedge clk);
    #1 vsync = 1'b1;
    @(posedge clk);
    #1 vsync = 1'b0;
    @(negedge clk);
    check("flush_vsync_ignored", disp_sel, 1);
    check("flush_still_stalled", bus.mem_wr_en, 1);
    cyc(1);
    bus.mem_wr_ready = 1'b1;
    drain();
    cyc(3);
    check("wait_disp_sel", disp_sel, 1);
    check("wait_no_fs", frame_start, 0);
    vsync = 1'b1;
    cyc(1);
    vsync = 1'b0;
    @(negedge clk);
    check("swap_disp_sel", disp_sel, 0);
    check("swap_fs_not_yet", frame_start, 0);
    @(negedge clk);
    check("swap_fs_pulse", frame_start, 1);
    @(negedge clk);
    check("swap_fs_single", frame_start, 0);
    exp_bank = 1'b1;
    cyc(1);
    send(10'd1, 10'd0, 3'd2, 1'b1, 19'd1, w);
    bus.px_valid = 1'b0;
    drain();

    // Reset while a write is stalled discards it
    bus.mem_wr_ready = 1'b0;
    send(10'd7, 10'd7, 3'd6, 1'b1, 19'd4487, w);
    bus.px_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_stalled", bus.mem_wr_en, 1);
    w0 = wr_cnt;
    @(posedge clk);
    #1 rst = 1'b1;
    cyc(1);
    @(negedge clk);
    check("midrst_wr_en", bus.mem_wr_en, 0);
    check("midrst_addr", bus.mem_addr, 0);
    check("midrst_px_ready", bus.px_ready, 0);
    check("midrst_drop_cnt", drop_cnt, 0);
    check("midrst_disp_sel", disp_sel, 1);
    check("midrst_fs", frame_start, 0);
    sb.delete();
    exp_bank = 1'b0;
    exp_drop = 0;
    cyc(1);
    bus.mem_wr_ready = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    @(negedge clk);
    check("rerst_fs", frame_start, 1);
    cyc(6);
    check("rerst_no_write", wr_cnt - w0, 0);
    send(10'd2, 10'd1, 3'd3, 1'b1, 19'd642, w);
    bus.px_valid = 1'b0;
    drain();
    check("final_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
